// File: rtl/imem_program_loader.sv
// Instruction-store writer: clears DEPTH words to NOP, then packs a little-endian byte stream into word writes.
// Holds the CPU off (cpu_hold) for the whole load; abort or reset drops the partial word.
module imem_program_loader #(
  parameter int          DEPTH    = 128,
  parameter int          ADDR_W   = 7,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        load_len,
  input  logic              abort,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [7:0]        word_count,
  output logic              busy,
  output logic              done,
  output logic              cpu_hold
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RECV,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [7:0]        DEPTH_LEN = 8'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       asm_q, asm_d;
  logic [31:0]       data_q, data_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        wcnt_q, wcnt_d;
  logic              accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      data_q     <= '0;
      len_q      <= '0;
      wcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      data_q     <= data_d;
      len_q      <= len_d;
      wcnt_q     <= wcnt_d;
    end
  end

  // abort gates both the handshake and the write strobe so it wins in the same cycle
  assign byte_ready = (state_q == S_RECV) && !abort;
  assign wr_en      = ((state_q == S_CLEAR) || (state_q == S_WRITE)) && !abort;
  assign accept     = byte_ready && byte_valid;
  assign busy       = (state_q == S_CLEAR) || (state_q == S_RECV) || (state_q == S_WRITE);
  assign cpu_hold   = busy;
  assign done       = (state_q == S_DONE);
  assign wr_addr    = addr_q;
  assign wr_data    = data_q;
  assign word_count = wcnt_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    data_d     = data_q;
    len_d      = len_q;
    wcnt_d     = wcnt_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          len_d      = (load_len > DEPTH_LEN) ? DEPTH_LEN : load_len;
          wcnt_d     = '0;
          addr_d     = '0;
          byte_cnt_d = '0;
          asm_d      = '0;
          data_d     = NOP_WORD;
          state_d    = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (abort) begin
          addr_d  = '0;
          state_d = S_IDLE;
        end else if (addr_q == LAST_ADDR) begin
          addr_d  = '0;
          state_d = (len_q != 8'd0) ? S_RECV : S_DONE;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      S_RECV: begin
        if (abort) begin
          byte_cnt_d = '0;
          asm_d      = '0;
          state_d    = S_IDLE;
        end else if (accept) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0: asm_d[7:0]   = byte_data;
            2'd1: asm_d[15:8]  = byte_data;
            2'd2: asm_d[23:16] = byte_data;
            default: begin
              data_d  = {byte_data, asm_q};
              state_d = S_WRITE;
            end
          endcase
        end
      end
      S_WRITE: begin
        if (abort) begin
          byte_cnt_d = '0;
          asm_d      = '0;
          state_d    = S_IDLE;
        end else begin
          wcnt_d  = wcnt_q + 8'd1;
          addr_d  = addr_q + ADDR_W'(1);
          state_d = ((wcnt_q + 8'd1) == len_q) ? S_DONE : S_RECV;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_imem_program_loader.sv
// Scoreboarded bench for imem_program_loader: expected writes are queued by the stimulus,
// a negedge monitor pops and compares every wr_en cycle and mirrors writes into a memory image.
module tb_imem_program_loader;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] load_len = '0;
  logic       abort = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = '0;
  logic       byte_ready, wr_en, busy, done, cpu_hold;
  logic [6:0] wr_addr;
  logic [31:0] wr_data;
  logic [7:0] word_count;

  int errors = 0;
  int checks = 0;

  logic [38:0] exp_q[$];
  logic [7:0]  bytes_q[$];
  logic [31:0] mem_img[128];
  logic [31:0] exp_mem[128];
  logic [6:0]  last_addr;
  int          wr_total;

  imem_program_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load_len(load_len), .abort(abort),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .word_count(word_count),
    .busy(busy), .done(done), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // monitor: every write strobe must match the head of the expected queue
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("wr_unexpected", {25'd0, wr_addr, wr_data}, 64'd0);
      end else begin
        logic [38:0] e;
        e = exp_q.pop_front();
        chk("wr_addr_data", {25'd0, wr_addr, wr_data}, {25'd0, e});
      end
      mem_img[wr_addr] = wr_data;
      last_addr = wr_addr;
      wr_total++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_clear();
    for (int a = 0; a < 128; a++) begin
      exp_q.push_back({7'(a), NOP});
      exp_mem[a] = NOP;
    end
  endtask

  task automatic push_word(input int a, input logic [31:0] w);
    exp_q.push_back({7'(a), w});
    exp_mem[a] = w;
  endtask

  task automatic do_start(input logic [7:0] n);
    start = 1'b1;
    load_len = n;
    cyc();
    start = 1'b0;
  endtask

  task automatic send_bytes(input bit gap);
    while (bytes_q.size() > 0) begin
      int n;
      byte_valid = 1'b1;
      byte_data = bytes_q.pop_front();
      n = 0;
      @(negedge clk);
      while (byte_ready !== 1'b1 && n < 1000) begin
        @(negedge clk);
        n++;
      end
      if (n >= 1000) begin
        chk("byte_ready_timeout", 64'd0, 64'd1);
        byte_valid = 1'b0;
        bytes_q.delete();
        return;
      end
      cyc();
      byte_valid = 1'b0;
      if (gap) cyc();
    end
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(name, {63'd0, done}, 64'd1);
  endtask

  task automatic check_mem(input string name);
    int bad;
    bad = 0;
    for (int a = 0; a < 128; a++) if (mem_img[a] !== exp_mem[a]) bad++;
    chk(name, 64'(bad), 64'd0);
    chk({name, "_queue_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic two_word_load(input bit gap);
    push_clear();
    push_word(0, 32'h0010_0513);
    push_word(1, 32'h0020_0593);
    do_start(8'd2);
    bytes_q = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    send_bytes(gap);
    wait_done(gap ? "gap_done" : "two_done");
    chk(gap ? "gap_word_count" : "two_word_count", 64'(word_count), 64'd2);
    chk(gap ? "gap_hold" : "two_hold", {62'd0, cpu_hold, busy}, 64'd0);
    check_mem(gap ? "gap_mem" : "two_mem");
  endtask

  initial begin
    wr_total = 0;
    last_addr = '0;
    #2;
    chk("reset_outputs", {wr_en, busy, done, cpu_hold, byte_ready, word_count, wr_addr, wr_data}, 64'd0);
    #20;
    rst_n = 1'b1;
    cyc();
    cyc();
    chk("idle_after_release", {61'd0, byte_ready, busy, done}, 64'd0);

    // clear only
    push_clear();
    do_start(8'd0);
    wait_done("clear_done");
    chk("clear_word_count", 64'(word_count), 64'd0);
    chk("clear_cpu_hold", {63'd0, cpu_hold}, 64'd0);
    chk("clear_last_addr", 64'(last_addr), 64'd127);
    check_mem("clear_mem");

    two_word_load(1'b0);
    two_word_load(1'b1);

    // abort after the 6th byte of a 3-word load
    push_clear();
    push_word(0, 32'h0010_0513);
    do_start(8'd3);
    bytes_q = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05};
    send_bytes(1'b0);
    abort = 1'b1;
    @(negedge clk);
    chk("abort_blocks_ready", {63'd0, byte_ready}, 64'd0);
    cyc();
    abort = 1'b0;
    @(negedge clk);
    chk("abort_idle", {61'd0, busy, done, byte_ready}, 64'd0);
    chk("abort_word_count", 64'(word_count), 64'd1);
    chk("abort_mem1_nop", 64'(mem_img[1]), 64'(NOP));
    check_mem("abort_mem");

    push_clear();
    push_word(0, 32'h4433_2211);
    do_start(8'd1);
    bytes_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_bytes(1'b0);
    wait_done("reload_done");
    chk("reload_word_count", 64'(word_count), 64'd1);
    check_mem("reload_mem");
    cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    @(negedge clk);
    chk("abort_in_done_ignored", {63'd0, done}, 64'd1);

    // clamp: 200 requested, 128 written
    push_clear();
    for (int k = 0; k < 128; k++)
      push_word(k, {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
    for (int i = 0; i < 512; i++) bytes_q.push_back(8'(i));
    wr_total = 0;
    do_start(8'd200);
    send_bytes(1'b0);
    wait_done("clamp_done");
    chk("clamp_word_count", 64'(word_count), 64'd128);
    chk("clamp_writes", 64'(wr_total), 64'd256);
    chk("clamp_last_addr", 64'(last_addr), 64'd127);
    chk("clamp_ready_low", {63'd0, byte_ready}, 64'd0);
    chk("clamp_mem127", 64'(mem_img[127]), 64'h0000_0000_FFFE_FDFC);
    check_mem("clamp_mem");

    // asynchronous reset in the middle of a clear
    push_clear();
    do_start(8'd5);
    for (int i = 0; i < 9; i++) cyc();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs",
        {wr_en, busy, done, cpu_hold, byte_ready, word_count, wr_addr, wr_data}, 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    cyc();
    chk("post_reset_idle", {61'd0, byte_ready, busy, done}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Writer side of the instruction memory: fills the 128-word instruction store at run time, replacing file preload.
- Clears the store to NOP, then accepts a byte stream over a valid/ready handshake.
- Assembles bytes into little-endian 32-bit words and issues one word-aligned write per word.
- Holds the pipeline off (cpu_hold) while loading; sits between the host/debug byte source and the memory write port.

Parameters:
- DEPTH, 128, number of 32-bit instruction words.
- ADDR_W, 7, word-address width (log2 DEPTH).
- NOP_WORD, 32'h00000013, fill value written during clear (addi x0,x0,0).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  load request; sampled only in IDLE or DONE.
- load_len  input  8  number of words to receive; sampled with start; values >DEPTH clamp to DEPTH.
- abort  input  1  cancel an in-progress load.
- byte_valid  input  1  byte_data is valid.
- byte_data  input  8  program byte; the first byte of each word goes to bits [7:0].
- byte_ready  output  1  loader accepts a byte this cycle.
- wr_en  output  1  memory write strobe, one cycle per word.
- wr_addr  output  ADDR_W  word address (byte address = wr_addr<<2).
- wr_data  output  32  word to write.
- word_count  output  8  words written during the receive phase of the current or last load.
- busy  output  1  high in CLEAR, RECV or WRITE.
- done  output  1  high in DONE; cleared when the next start is accepted.
- cpu_hold  output  1  equals busy; holds pipeline PC/fetch.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; every output 0.
  - Internal byte counter, word address and assembly register cleared.
  - Release is synchronous to clk.
- States: IDLE, CLEAR, RECV, WRITE, DONE. All transitions happen on the clk edge.
- IDLE/DONE:
  - If start=1: latch len=min(load_len,DEPTH), set word_count=0, clear done, go to CLEAR with addr=0.
  - start outside IDLE/DONE is ignored.
- CLEAR:
  - wr_en=1, wr_data=NOP_WORD, wr_addr=addr; addr increments each cycle.
  - Takes exactly DEPTH cycles (addresses 0..DEPTH-1).
  - After address DEPTH-1: addr=0; go to RECV if len>0, else go to DONE.
- RECV:
  - byte_ready=1.
  - A byte is accepted when byte_valid and byte_ready are both 1. It is placed in lane byte_cnt (0→[7:0], 1→[15:8], 2→[23:16], 3→[31:24]); byte_cnt increments mod 4.
  - On acceptance of lane 3, go to WRITE.
  - byte_valid=0 causes a stall with no state change.
- WRITE:
  - byte_ready=0, wr_en=1, wr_addr=addr, wr_data=assembled word.
  - Next cycle: word_count+1, addr+1.
  - If word_count+1==len go to DONE, else return to RECV.
- Throughput: best case 5 cycles per word (4 accepts + 1 write).
- wr_en is 0 in IDLE, RECV and DONE. wr_addr/wr_data are don't-care when wr_en=0 but must be stable (registered).
- Wrap-around: addr never exceeds DEPTH-1 because len≤DEPTH; a clamped load of 255 writes 128 words and ends in DONE.
- Unloaded words: addresses ≥len retain NOP_WORD from CLEAR.
- abort:
  - In CLEAR/RECV/WRITE: go to IDLE next edge; the partial word is discarded and no write occurs that cycle.
  - Words already written remain; done stays 0; word_count holds its value.
  - abort has priority over a byte accept or write in the same cycle.
  - abort in IDLE/DONE is ignored; done persists in DONE.
- Reset mid-load: behaves like abort, but all outputs return to 0 (including word_count).

Test Plan:
- Reset then idle: rst_n=0 mid-CLEAR → all outputs 0 immediately (async). After release: IDLE, byte_ready=0.
- Clear only: start, load_len=0 → 128 wr_en cycles, addr 0..127, data 32'h00000013, then done=1, word_count=0, cpu_hold=0.
- Two-word load: load_len=2, bytes 13 05 10 00 93 05 20 00 streamed every cycle → mem[0]=32'h00100513, mem[1]=32'h00200593, each wr_en exactly 1 cycle; word_count=2, done=1, mem[2..127]=NOP.
- Backpressure/gaps: same stream with byte_valid=0 on alternating cycles → identical memory contents; no byte lost or duplicated.
- Abort: load_len=3, abort after the 6th byte → IDLE, only mem[0] updated, mem[1] stays NOP, done=0, word_count=1. A following start/load_len=1 completes normally.
- Clamp: load_len=200 with 512 bytes → exactly 128 writes, last at wr_addr=127, word_count=128, byte_ready=0 after DONE.
